// File: rtl/stim_event_player.sv
// Event replay source: queued (delta, data, last) events are applied to q_out
// in order, each after its own delay, with a one-cycle q_update strobe.
module stim_event_player #(
    parameter int DATA_W  = 4,
    parameter int DELTA_W = 8,
    parameter int DEPTH   = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DELTA_W-1:0] in_delta,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    input  logic               start,
    input  logic               stop,
    output logic [DATA_W-1:0]  q_out,
    output logic               q_update,
    output logic               busy,
    output logic               done,
    output logic               underrun
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = DELTA_W + DATA_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        STALL
    } state_t;

    logic [EW-1:0] mem_q [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    state_t state_q, state_d;

    logic [DELTA_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  dat_q, dat_d;
    logic               lst_q, lst_d;
    logic [DATA_W-1:0]  q_out_q, q_out_d;
    logic               q_update_q, q_update_d;
    logic               done_q, done_d;
    logic               underrun_q, underrun_d;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic flush;

    logic [EW-1:0]      head;
    logic [DELTA_W-1:0] head_delta;
    logic [DATA_W-1:0]  head_data;
    logic               head_last;

    // Extra pointer bit distinguishes full from empty when indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign head_delta = head[EW-1 -: DELTA_W];
    assign head_data  = head[DATA_W:1];
    assign head_last  = head[0];

    assign push = in_valid && !full && !stop;

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_delta, in_data, in_last};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dat_d      = dat_q;
        lst_d      = lst_q;
        q_out_d    = q_out_q;
        q_update_d = 1'b0;
        done_d     = 1'b0;
        underrun_d = underrun_q;
        pop        = 1'b0;
        flush      = 1'b0;

        if (stop) begin
            flush   = 1'b1;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !empty) begin
                        pop        = 1'b1;
                        underrun_d = 1'b0;
                        state_d    = COUNT;
                    end
                end
                COUNT: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        q_out_d    = dat_q;
                        q_update_d = 1'b1;
                        if (lst_q) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else if (!empty) begin
                            pop = 1'b1;
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = STALL;
                        end
                    end
                end
                STALL: begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = COUNT;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (pop) begin
            cnt_d = head_delta;
            dat_d = head_data;
            lst_d = head_last;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            dat_q      <= '0;
            lst_q      <= 1'b0;
            q_out_q    <= '0;
            q_update_q <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dat_q      <= dat_d;
            lst_q      <= lst_d;
            q_out_q    <= q_out_d;
            q_update_q <= q_update_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    assign in_ready = !full;
    assign q_out    = q_out_q;
    assign q_update = q_update_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_stim_event_player.sv
// Randomized bench for stim_event_player: a timestamp-based reference model
// predicts each applied event; a monitor matches DUT updates against it.
module tb_stim_event_player;

    localparam int DATA_W  = 4;
    localparam int DELTA_W = 8;
    localparam int DEPTH   = 4;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic [DELTA_W-1:0] in_delta;
    logic [DATA_W-1:0]  in_data;
    logic               in_last;
    logic               start;
    logic               stop;
    logic [DATA_W-1:0]  q_out;
    logic               q_update;
    logic               busy;
    logic               done;
    logic               underrun;

    stim_event_player #(
        .DATA_W (DATA_W),
        .DELTA_W(DELTA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_delta(in_delta),
        .in_data (in_data),
        .in_last (in_last),
        .start   (start),
        .stop    (stop),
        .q_out   (q_out),
        .q_update(q_update),
        .busy    (busy),
        .done    (done),
        .underrun(underrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int delta;
        int data;
        bit last;
    } ev_t;

    typedef struct {
        int cyc;
        int data;
        bit last;
    } exp_t;

    ev_t  mq[$];
    exp_t sb[$];

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;
    bit armed    = 0;

    bit  m_play  = 0;
    bit  m_stall = 0;
    bit  m_under = 0;
    int  m_q     = 0;
    int  m_due   = 0;
    ev_t m_cur;

    always @(posedge clock) edge_cnt++;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)",
                     name, act, exp, edge_cnt);
        end
    endtask

    // Applied events are keyed by the absolute edge on which they must land.
    always @(negedge clock) begin
        exp_t x;
        if (armed) begin
            if (q_update) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update: q_out %0d at edge %0d",
                             q_out, edge_cnt);
                end else begin
                    x = sb.pop_front();
                    chk("update_edge", edge_cnt, x.cyc);
                    chk("update_data", 32'(q_out), x.data);
                    chk("update_done", 32'(done), 32'(x.last));
                end
            end else begin
                chk("done_without_update", 32'(done), 0);
            end
        end
    end

    task automatic step(bit rn, bit v, int d, int dat, bit l, bit st, bit sp);
        int  ed;
        bit  acc;
        ev_t nev;
        @(negedge clock);
        if (armed) begin
            chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
            chk("busy", 32'(busy), 32'(m_play));
            chk("underrun", 32'(underrun), 32'(m_under));
            chk("q_out", 32'(q_out), m_q);
        end
        reset_n  = rn;
        in_valid = v;
        in_delta = DELTA_W'(d);
        in_data  = DATA_W'(dat);
        in_last  = l;
        start    = st;
        stop     = sp;
        ed = edge_cnt + 1;
        if (!rn) begin
            mq.delete();
            m_play  = 0;
            m_stall = 0;
            m_under = 0;
            m_q     = 0;
        end else if (sp) begin
            mq.delete();
            m_play  = 0;
            m_stall = 0;
        end else begin
            acc = v && (mq.size() < DEPTH);
            if (!m_play) begin
                if (st && mq.size() > 0) begin
                    m_cur   = mq.pop_front();
                    m_due   = ed + m_cur.delta + 1;
                    m_under = 0;
                    m_play  = 1;
                end
            end else if (m_stall) begin
                if (mq.size() > 0) begin
                    m_cur   = mq.pop_front();
                    m_due   = ed + m_cur.delta + 1;
                    m_stall = 0;
                end
            end else if (ed == m_due) begin
                sb.push_back('{ed, m_cur.data, m_cur.last});
                m_q = m_cur.data;
                if (m_cur.last) begin
                    m_play = 0;
                end else if (mq.size() > 0) begin
                    m_cur = mq.pop_front();
                    m_due = ed + m_cur.delta + 1;
                end else begin
                    m_under = 1;
                    m_stall = 1;
                end
            end
            if (acc) begin
                nev = '{d, dat, l};
                mq.push_back(nev);
            end
        end
    endtask

    task automatic push(int d, int dat, bit l);
        step(1, 1, d, dat, l, 0, 0);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic go();
        step(1, 0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        int guard;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        in_delta = '0;
        in_data  = '0;
        in_last  = 1'b0;
        start    = 1'b0;
        stop     = 1'b0;
        repeat (2) @(posedge clock);
        armed = 1;

        push(0, 1, 0);
        push(0, 15, 0);
        push(2, 3, 1);
        go();
        idle(8);

        for (int i = 0; i < 5; i++) push(1, i + 6, i == 4);
        go();
        idle(14);

        push(1, 5, 0);
        go();
        idle(4);
        push(0, 10, 1);
        idle(4);

        push(3, 7, 0);
        push(0, 8, 0);
        push(0, 9, 1);
        go();
        idle(1);
        step(1, 0, 0, 0, 0, 0, 1);
        idle(6);

        push(0, 2, 0);
        push(5, 4, 1);
        go();
        idle(2);
        step(0, 1, 0, 12, 1, 0, 0);
        idle(3);

        push(1, 11, 0);
        go();
        push(0, 13, 1);
        idle(5);

        for (int n = 0; n < 4000; n++) begin
            int  d;
            bit  rn;
            rn = ($urandom_range(0, 199) != 0);
            d  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 20)
                                             : $urandom_range(0, 2);
            step(rn, 1'($urandom_range(0, 1)), d, $urandom_range(0, 15),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 59) == 0));
        end

        guard = 0;
        while (m_play && !m_stall && guard < 200) begin
            idle(1);
            guard++;
        end
        idle(2);
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
